ahb_display: RTL and testbench
==============================

Name: ahb_display

Overview:
- AHB-Lite slave that drives a multiplexed 8-digit, 7-segment display with decimal points.
- Software writes per-digit raw segment patterns, a 32-bit hex value and a control word.
- The block time-multiplexes the digits and drives active-low digit-select and segment lines.
- Sits on the peripheral AHB bus next to the other memory-mapped slaves.

Parameters:
- D_WIDTH, default 18: width of the dwell prescaler. Each digit is shown for 2^D_WIDTH HCLK cycles; 5 gives fast simulation.

Ports:
- HCLK  in  1  bus clock; only clock.
- HRESETn  in  1  reset; synchronous, active-high (asserted when 1, sampled on HCLK rising edge).
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready (transfer advances when 1).
- HADDR  in  32  address; only bits [3:2] decoded.
- HTRANS  in  2  transfer type; only bit 1 used (NONSEQ/SEQ = active).
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready; constant 1 (zero wait states).
- digit  out  8  digit selects, active-low; bit n = digit n (digit 0 rightmost).
- segment  out  8  segments, active-low; bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- No HSIZE input. Every write updates the full 32-bit register.
- Register map, selected by HADDR[3:2]:
  - 0x0 RAWLO: byte n = raw pattern for digit n (n = 0..3).
  - 0x4 RAWHI: byte n-4 = raw pattern for digit n (n = 4..7).
  - 0x8 VALUE: nibble n = hex value for digit n.
  - 0xC CTRL: [23:16] digit-enable mask; [15:8] hex-mode mask (1 = decode VALUE nibble, 0 = raw pattern); [7:0] decimal-point mask; [31:24] read as 0 and ignore writes.
- Raw pattern bit = 1 lights that segment.
- Address phase: when HSEL & HTRANS[1] & HREADY, register the write flag and HADDR[3:2]. Otherwise clear the write flag.
- Data phase: at the next HCLK edge a pending write loads HWDATA into the selected register.
- HRDATA is combinational from the register selected by the captured address. A read that immediately follows a write to the same address returns the new value.
- Multiplexing:
  - Free-running counter of D_WIDTH+3 bits; top 3 bits = current digit index k, cycling 0..7 then wrapping.
  - Segment code for digit k: hex mask bit k ? hex-decode(VALUE nibble k) : raw byte k. Bit 7 is ORed with dp mask bit k in both modes.
  - Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - digit and segment are registered, with one cycle latency from counter to outputs.
  - If enable mask bit k = 1: digit = ~(1<<k) and segment = ~code.
  - If enable mask bit k = 0: digit = 8'hFF and segment = 8'hFF.
- Reset: all registers 0, counter 0, pending-write flag 0, digit = 8'hFF, segment = 8'hFF. Display is blank until CTRL is written.
- Reset asserted during a data phase aborts the pending write.

Decomposition:
- Shared package ahb_display_pkg:
  - register offset constants (RAWLO/RAWHI/VALUE/CTRL);
  - HTRANS codes (IDLE = 2'b00, NONSEQ = 2'b10);
  - CTRL field bit positions.
- One sub-module: seg7_hex_decode (4-bit value in, 7-bit active-high pattern out, combinational).

Test Plan:
- Write 0x0 = 08040201, 0x4 = 80402010, 0x8 = 76543210, 0xC = 00FF0000, then read all four -> reads return 08040201, 80402010, 76543210, 00FF0000; HREADYOUT stays 1 throughout.
- Raw mode (CTRL = 00FF0000, D_WIDTH = 5) -> digits cycle FE, FD, … 7F, 32 clocks each; digit 0 segment = FE, digit 4 = EF, digit 7 = 7F.
- CTRL = 00FFFF08 -> hex mode on all digits: digit 3 segment = 30 (3 with dp), digit 0 = C0, digit 7 = F8.
- CTRL = 003F0F01 -> digits 6 and 7 blank (digit = FF, segment = FF); digits 0-3 hex with digit 0 = 40 (0 with dp); digits 4-5 raw, digit 4 = EF.
- Reset held during display activity -> next cycle digit = FF, segment = FF, all reads return 0.
- Write 0xC = FFFFFFFF, read back -> 00FFFFFF; back-to-back write then read of 0x8 returns the new value with no wait states.

Source files
------------

// File: rtl/ahb_display_pkg.sv
// Shared constants for the AHB-Lite multiplexed 7-segment display slave:
// register offsets, HTRANS codes and CTRL field positions.
package ahb_display_pkg;

    localparam logic [1:0] ADDR_RAWLO = 2'd0;
    localparam logic [1:0] ADDR_RAWHI = 2'd1;
    localparam logic [1:0] ADDR_VALUE = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam int CTRL_W       = 24;
    localparam int CTRL_EN_LSB  = 16;
    localparam int CTRL_HEX_LSB = 8;
    localparam int CTRL_DP_LSB  = 0;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module seg7_hex_decode (
    input  logic [3:0] value_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = 7'h00;
        case (value_i)
            4'h0: pattern_o = 7'h3F;
            4'h1: pattern_o = 7'h06;
            4'h2: pattern_o = 7'h5B;
            4'h3: pattern_o = 7'h4F;
            4'h4: pattern_o = 7'h66;
            4'h5: pattern_o = 7'h6D;
            4'h6: pattern_o = 7'h7D;
            4'h7: pattern_o = 7'h07;
            4'h8: pattern_o = 7'h7F;
            4'h9: pattern_o = 7'h6F;
            4'hA: pattern_o = 7'h77;
            4'hB: pattern_o = 7'h7C;
            4'hC: pattern_o = 7'h39;
            4'hD: pattern_o = 7'h5E;
            4'hE: pattern_o = 7'h79;
            4'hF: pattern_o = 7'h71;
            default: pattern_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/ahb_display.sv
// AHB-Lite slave driving an 8-digit multiplexed 7-segment display with decimal points.
// Zero-wait-state: HREADYOUT is tied high, so every data phase completes in one cycle.
module ahb_display
    import ahb_display_pkg::*;
#(
    parameter int D_WIDTH = 18
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [7:0]  digit,
    output logic [7:0]  segment
);

    localparam int CW = D_WIDTH + 3;

    logic              write_q, write_d;
    logic [1:0]        addr_q, addr_d;
    logic [31:0]       rawlo_q, rawlo_d;
    logic [31:0]       rawhi_q, rawhi_d;
    logic [31:0]       value_q, value_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        digit_q, digit_d;
    logic [7:0]        segment_q, segment_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic        active;
    logic [2:0]  k;
    logic [63:0] raw_all;
    logic [3:0]  nibble;
    logic [6:0]  hex_pat;
    logic [7:0]  en_mask, hex_mask, dp_mask;
    logic [7:0]  code;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

    assign active    = HSEL & HTRANS[1] & HREADY;
    assign HREADYOUT = 1'b1;
    assign digit     = digit_q;
    assign segment   = segment_q;

    always_comb begin
        HRDATA = 32'h0;
        case (addr_q)
            ADDR_RAWLO: HRDATA = rawlo_q;
            ADDR_RAWHI: HRDATA = rawhi_q;
            ADDR_VALUE: HRDATA = value_q;
            ADDR_CTRL:  HRDATA = {{(32-CTRL_W){1'b0}}, ctrl_q};
            default:    HRDATA = 32'h0;
        endcase
    end

    // Bus side: capture the address phase, commit the write in the following data phase.
    always_comb begin
        write_d = 1'b0;
        addr_d  = addr_q;
        rawlo_d = rawlo_q;
        rawhi_d = rawhi_q;
        value_d = value_q;
        ctrl_d  = ctrl_q;
        if (active) begin
            write_d = HWRITE;
            addr_d  = HADDR[3:2];
        end
        if (write_q) begin
            case (addr_q)
                ADDR_RAWLO: rawlo_d = HWDATA;
                ADDR_RAWHI: rawhi_d = HWDATA;
                ADDR_VALUE: value_d = HWDATA;
                ADDR_CTRL:  ctrl_d  = HWDATA[CTRL_W-1:0];
                default:    ;
            endcase
        end
    end

    assign k        = cnt_q[CW-1 -: 3];
    assign raw_all  = {rawhi_q, rawlo_q};
    assign nibble   = value_q[{k, 2'b00} +: 4];
    assign en_mask  = ctrl_q[CTRL_EN_LSB +: 8];
    assign hex_mask = ctrl_q[CTRL_HEX_LSB +: 8];
    assign dp_mask  = ctrl_q[CTRL_DP_LSB +: 8];

    seg7_hex_decode u_hex (
        .value_i   (nibble),
        .pattern_o (hex_pat)
    );

    // Display side: outputs lag the counter by one cycle.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        code      = hex_mask[k] ? {1'b0, hex_pat} : raw_all[{k, 3'b000} +: 8];
        code[7]   = code[7] | dp_mask[k];
        digit_d   = 8'hFF;
        segment_d = 8'hFF;
        if (en_mask[k]) begin
            digit_d   = ~(8'h01 << k);
            segment_d = ~code;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            write_q   <= 1'b0;
            addr_q    <= 2'd0;
            rawlo_q   <= 32'h0;
            rawhi_q   <= 32'h0;
            value_q   <= 32'h0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            digit_q   <= 8'hFF;
            segment_q <= 8'hFF;
        end else begin
            write_q   <= write_d;
            addr_q    <= addr_d;
            rawlo_q   <= rawlo_d;
            rawhi_q   <= rawhi_d;
            value_q   <= value_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            segment_q <= segment_d;
        end
    end

endmodule

// File: tb/tb_ahb_display.sv
// Self-checking bench for ahb_display: directed register/display cases plus
// randomized register traffic checked against a register-map and display model.
module tb_ahb_display;
    import ahb_display_pkg::*;

    localparam int DW    = 5;
    localparam int DWELL = 1 << DW;

    logic        HCLK = 1'b0;
    logic        rst;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [7:0]  digit;
    logic [7:0]  segment;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] m_reg [4];
    logic [6:0]  hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    ahb_display #(.D_WIDTH(DW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (rst),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .digit     (digit),
        .segment   (segment)
    );

    always #5 HCLK = ~HCLK;

    // Elapsed clocks since reset release; the display counter should equal this.
    always @(posedge HCLK) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        m_reg[a] = (a == ADDR_CTRL) ? (d & 32'h00FF_FFFF) : d;
    endtask

    function automatic logic [15:0] model_display(input int k);
        logic [63:0] raw;
        logic [7:0]  code;
        raw = {m_reg[1], m_reg[0]};
        if (!m_reg[3][16 + k]) return 16'hFFFF;
        if (m_reg[3][8 + k]) code = {1'b0, hex_lut[m_reg[2][4*k +: 4]]};
        else                 code = raw[8*k +: 8];
        code[7] = code[7] | m_reg[3][k];
        return {~(8'h01 << k), ~code};
    endfunction

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {28'h0, a, 2'b00};
        @(negedge HCLK);
        bus_idle();
        HWDATA = d;
        model_write(a, d);
    endtask

    task automatic bus_read_check(input logic [1:0] a, input string tag);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {28'h0, a, 2'b00};
        @(negedge HCLK);
        bus_idle();
        check(tag, HRDATA, m_reg[a]);
        check("hreadyout", {31'h0, HREADYOUT}, 32'h1);
    endtask

    task automatic check_now(input string tag);
        int k;
        logic [15:0] e;
        k = ((cyc - 1) >> DW) & 7;
        e = model_display(k);
        check({tag, "_digit"}, {24'h0, digit}, {24'h0, e[15:8]});
        check({tag, "_seg"}, {24'h0, segment}, {24'h0, e[7:0]});
    endtask

    // One sample per dwell period across all eight digits.
    task automatic sweep(input string tag);
        repeat (2) @(negedge HCLK);
        for (int i = 0; i < 8; i++) begin
            check_now(tag);
            repeat (DWELL) @(negedge HCLK);
        end
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        rst = 1'b1; HREADY = 1'b1; HADDR = 32'h0; HWDATA = 32'h0;
        bus_idle();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        repeat (3) @(negedge HCLK);
        check("rst_digit", {24'h0, digit}, 32'hFF);
        check("rst_seg", {24'h0, segment}, 32'hFF);
        rst = 1'b0;
        sweep("blank");

        bus_write(ADDR_RAWLO, 32'h0804_0201);
        bus_write(ADDR_RAWHI, 32'h8040_2010);
        bus_write(ADDR_VALUE, 32'h7654_3210);
        bus_write(ADDR_CTRL,  32'h00FF_0000);
        for (int i = 0; i < 4; i++) bus_read_check(i[1:0], "read_init");
        check("read_rawlo_const", m_reg[0], 32'h0804_0201);
        sweep("raw");

        bus_write(ADDR_CTRL, 32'h00FF_FF08);
        sweep("hex");
        bus_write(ADDR_CTRL, 32'h003F_0F01);
        sweep("mixed");

        bus_write(ADDR_CTRL, 32'hFFFF_FFFF);
        bus_read_check(ADDR_CTRL, "ctrl_mask");

        // Write immediately followed by a read of the same register.
        d = 32'hA5C3_1E0F;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h8;
        @(negedge HCLK);
        HWDATA = d; HWRITE = 1'b0; HADDR = 32'h8;
        model_write(ADDR_VALUE, d);
        @(negedge HCLK);
        bus_idle();
        check("b2b_read", HRDATA, d);
        check("b2b_ready", {31'h0, HREADYOUT}, 32'h1);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(1, 4)) begin
                a = 2'($urandom_range(0, 3));
                d = $urandom;
                bus_write(a, d);
            end
            bus_read_check(2'($urandom_range(0, 3)), "rand_read");
            repeat (2) @(negedge HCLK);
            repeat (4) begin
                repeat ($urandom_range(1, 3 * DWELL)) @(negedge HCLK);
                check_now("rand_disp");
            end
        end

        bus_write(ADDR_CTRL, 32'h00FF_FFFF);
        repeat (3 * DWELL) @(negedge HCLK);
        // Reset arrives in the data phase of a pending write.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h0;
        @(negedge HCLK);
        bus_idle();
        HWDATA = 32'hDEAD_BEEF;
        rst = 1'b1;
        @(negedge HCLK);
        check("rst2_digit", {24'h0, digit}, 32'hFF);
        check("rst2_seg", {24'h0, segment}, 32'hFF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 4; i++) bus_read_check(i[1:0], "read_after_rst");
        sweep("blank2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
